nasti_wr_sched: RTL and testbench

Write-path scheduler that shares one NASTI slave port among up to 8 NASTI masters. Arbitrates AW requests round-robin, holds the W channel on the winner until `w_last`, and returns each B response to the master that issued the matching AW. It sits in front of a shared peripheral or memory port, the mirror of the address-decoding demux on the fan-out side. Read channels are out of scope; a separate read scheduler handles them.

---
 rtl/nasti_wr_sched.sv | 205 ++++++++++++++++++++
 tb/tb_nasti_wr_sched.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_wr_sched.sv
// Write-path scheduler: N_PORT NASTI masters share one slave port (AW/W/B).
// Optional NASTI_WR_SCHED_LEN_CHK_EN adds a beat counter and sticky err flag.
module nasti_wr_sched #(
   parameter int N_PORT     = 4,
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1,
   parameter int B_DEPTH    = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_PORT-1:0]                    s_aw_valid,
   output logic [N_PORT-1:0]                    s_aw_ready,
   input  logic [N_PORT-1:0][ID_WIDTH-1:0]      s_aw_id,
   input  logic [N_PORT-1:0][ADDR_WIDTH-1:0]    s_aw_addr,
   input  logic [N_PORT-1:0][7:0]               s_aw_len,
   input  logic [N_PORT-1:0][2:0]               s_aw_size,
   input  logic [N_PORT-1:0][1:0]               s_aw_burst,
   input  logic [N_PORT-1:0]                    s_aw_lock,
   input  logic [N_PORT-1:0][3:0]               s_aw_cache,
   input  logic [N_PORT-1:0][2:0]               s_aw_prot,
   input  logic [N_PORT-1:0][3:0]               s_aw_qos,
   input  logic [N_PORT-1:0][3:0]               s_aw_region,
   input  logic [N_PORT-1:0][USER_WIDTH-1:0]    s_aw_user,
   input  logic [N_PORT-1:0]                    s_w_valid,
   output logic [N_PORT-1:0]                    s_w_ready,
   input  logic [N_PORT-1:0][DATA_WIDTH-1:0]    s_w_data,
   input  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]  s_w_strb,
   input  logic [N_PORT-1:0]                    s_w_last,
   input  logic [N_PORT-1:0][USER_WIDTH-1:0]    s_w_user,
   output logic [N_PORT-1:0]                    s_b_valid,
   input  logic [N_PORT-1:0]                    s_b_ready,
   output logic [N_PORT-1:0][ID_WIDTH-1:0]      s_b_id,
   output logic [N_PORT-1:0][1:0]               s_b_resp,
   output logic [N_PORT-1:0][USER_WIDTH-1:0]    s_b_user,
   output logic                                 m_aw_valid,
   input  logic                                 m_aw_ready,
   output logic [ID_WIDTH-1:0]                  m_aw_id,
   output logic [ADDR_WIDTH-1:0]                m_aw_addr,
   output logic [7:0]                           m_aw_len,
   output logic [2:0]                           m_aw_size,
   output logic [1:0]                           m_aw_burst,
   output logic                                 m_aw_lock,
   output logic [3:0]                           m_aw_cache,
   output logic [2:0]                           m_aw_prot,
   output logic [3:0]                           m_aw_qos,
   output logic [3:0]                           m_aw_region,
   output logic [USER_WIDTH-1:0]                m_aw_user,
   output logic                                 m_w_valid,
   input  logic                                 m_w_ready,
   output logic [DATA_WIDTH-1:0]                m_w_data,
   output logic [DATA_WIDTH/8-1:0]              m_w_strb,
   output logic                                 m_w_last,
   output logic [USER_WIDTH-1:0]                m_w_user,
`ifdef NASTI_WR_SCHED_LEN_CHK_EN
   output logic                                 err,
`endif
   input  logic                                 m_b_valid,
   output logic                                 m_b_ready,
   input  logic [ID_WIDTH-1:0]                  m_b_id,
   input  logic [1:0]                           m_b_resp,
   input  logic [USER_WIDTH-1:0]                m_b_user
);

   localparam int GW = (N_PORT > 1) ? $clog2(N_PORT) : 1;
   localparam int PW = $clog2(B_DEPTH);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t          state;
   logic [GW-1:0]   gnt;
   logic [GW-1:0]   rr_ptr;
   logic [GW-1:0]   win;
   logic            any_req;
   logic [GW-1:0]   fifo_q [B_DEPTH];
   logic [PW-1:0]   wp;
   logic [PW-1:0]   rp;
   logic [PW:0]     cnt;
   logic            full;
   logic            empty;
   logic [GW-1:0]   head;
   logic            aw_hs;
   logic            w_hs;
   logic            b_hs;
   logic            w_done;

   // Round-robin search starting at rr_ptr, wrapping at N_PORT.
   always_comb begin
      win = rr_ptr;
      any_req = 1'b0;
      for (int k = 0; k < N_PORT; k++) begin
         int j;
         j = int'(rr_ptr) + k;
         if (j >= N_PORT) j = j - N_PORT;
         if (!any_req && s_aw_valid[j]) begin
            win = GW'(j);
            any_req = 1'b1;
         end
      end
   end

   assign full  = (cnt == (PW+1)'(B_DEPTH));
   assign empty = (cnt == '0);
   assign head  = fifo_q[rp];

   assign m_aw_valid  = (state == ADDR) & s_aw_valid[gnt];
   assign m_aw_id     = s_aw_id[gnt];
   assign m_aw_addr   = s_aw_addr[gnt];
   assign m_aw_len    = s_aw_len[gnt];
   assign m_aw_size   = s_aw_size[gnt];
   assign m_aw_burst  = s_aw_burst[gnt];
   assign m_aw_lock   = s_aw_lock[gnt];
   assign m_aw_cache  = s_aw_cache[gnt];
   assign m_aw_prot   = s_aw_prot[gnt];
   assign m_aw_qos    = s_aw_qos[gnt];
   assign m_aw_region = s_aw_region[gnt];
   assign m_aw_user   = s_aw_user[gnt];
   assign s_aw_ready  = (state == ADDR && m_aw_ready) ?
                        (N_PORT'(1) << gnt) : '0;
   assign aw_hs       = m_aw_valid & m_aw_ready;

   assign m_w_valid = (state == DATA) & s_w_valid[gnt];
   assign m_w_data  = s_w_data[gnt];
   assign m_w_strb  = s_w_strb[gnt];
   assign m_w_user  = s_w_user[gnt];
   assign s_w_ready = (state == DATA && m_w_ready) ?
                      (N_PORT'(1) << gnt) : '0;
   assign w_hs      = m_w_valid & m_w_ready;

   assign s_b_valid = empty ? '0 : (N_PORT'(m_b_valid) << head);
   assign m_b_ready = !empty & s_b_ready[head];
   assign s_b_id    = {N_PORT{m_b_id}};
   assign s_b_resp  = {N_PORT{m_b_resp}};
   assign s_b_user  = {N_PORT{m_b_user}};
   assign b_hs      = m_b_valid & m_b_ready;

`ifdef NASTI_WR_SCHED_LEN_CHK_EN
   logic [7:0] beats;
   logic       at_last;

   assign at_last  = (beats == 8'd0);
   assign m_w_last = at_last;
   assign w_done   = w_hs & at_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beats <= 8'd0;
         err   <= 1'b0;
      end else begin
         if (aw_hs)
            beats <= m_aw_len;
         else if (w_hs && !at_last)
            beats <= beats - 8'd1;
         if (w_hs && (s_w_last[gnt] != at_last))
            err <= 1'b1;
      end
   end
`else
   assign m_w_last = s_w_last[gnt];
   assign w_done   = w_hs & s_w_last[gnt];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         gnt    <= '0;
         rr_ptr <= '0;
      end else begin
         unique case (state)
            IDLE: if (any_req && !full) begin
               gnt   <= win;
               state <= ADDR;
            end
            ADDR: if (aw_hs) begin
               rr_ptr <= (gnt == GW'(N_PORT-1)) ? '0 : gnt + 1'b1;
               state  <= DATA;
            end
            DATA: if (w_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Grant history in AW order; the head routes the next B response.
   always_ff @(posedge clk) begin
      if (aw_hs) fifo_q[wp] <= gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (aw_hs) wp <= wp + 1'b1;
         if (b_hs)  rp <= rp + 1'b1;
         if (aw_hs && !b_hs)
            cnt <= cnt + 1'b1;
         else if (!aw_hs && b_hs)
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_nasti_wr_sched.sv
// Directed bench for nasti_wr_sched: masters, downstream slave and a
// transaction-level routing model checked every cycle.
module tb_nasti_wr_sched;
   localparam int N  = 4;
   localparam int IW = 1;
   localparam int BD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]          s_aw_valid, s_aw_ready, s_aw_lock;
   logic [N-1:0][IW-1:0]  s_aw_id;
   logic [N-1:0][7:0]     s_aw_addr, s_aw_len;
   logic [N-1:0][2:0]     s_aw_size, s_aw_prot;
   logic [N-1:0][1:0]     s_aw_burst;
   logic [N-1:0][3:0]     s_aw_cache, s_aw_qos, s_aw_region;
   logic [N-1:0][0:0]     s_aw_user, s_w_user, s_w_strb, s_b_user;
   logic [N-1:0]          s_w_valid, s_w_ready, s_w_last;
   logic [N-1:0][7:0]     s_w_data;
   logic [N-1:0]          s_b_valid, s_b_ready;
   logic [N-1:0][IW-1:0]  s_b_id;
   logic [N-1:0][1:0]     s_b_resp;
   logic                  m_aw_valid, m_aw_ready, m_aw_lock;
   logic [IW-1:0]         m_aw_id;
   logic [7:0]            m_aw_addr, m_aw_len;
   logic [2:0]            m_aw_size, m_aw_prot;
   logic [1:0]            m_aw_burst;
   logic [3:0]            m_aw_cache, m_aw_qos, m_aw_region;
   logic [0:0]            m_aw_user, m_w_user, m_w_strb, m_b_user;
   logic                  m_w_valid, m_w_ready, m_w_last;
   logic [7:0]            m_w_data;
   logic                  m_b_valid, m_b_ready;
   logic [IW-1:0]         m_b_id;
   logic [1:0]            m_b_resp;
`ifdef NASTI_WR_SCHED_LEN_CHK_EN
   logic                  err;
`endif

   logic          awv [N];
   logic [7:0]    awaddr [N];
   logic [7:0]    awlen [N];
   logic [IW-1:0] awid [N];
   logic          wv [N];
   logic [7:0]    wd [N];
   logic          wl [N];
   logic          bra [N];

   always_comb begin
      for (int p = 0; p < N; p++) begin
         s_aw_valid[p]  = awv[p];
         s_aw_addr[p]   = awaddr[p];
         s_aw_len[p]    = awlen[p];
         s_aw_id[p]     = awid[p];
         s_aw_size[p]   = 3'(p);
         s_aw_burst[p]  = 2'b01;
         s_aw_lock[p]   = 1'(p);
         s_aw_cache[p]  = 4'(p + 1);
         s_aw_prot[p]   = 3'(p);
         s_aw_qos[p]    = 4'(p);
         s_aw_region[p] = 4'(3 - p);
         s_aw_user[p]   = 1'(p);
         s_w_valid[p]   = wv[p];
         s_w_data[p]    = wd[p];
         s_w_strb[p]    = 1'b1;
         s_w_last[p]    = wl[p];
         s_w_user[p]    = 1'(p);
         s_b_ready[p]   = bra[p];
      end
   end

   // Downstream slave knobs and state
   logic          aw_rdy, wr_tog, wr_ph, b_en;
   int            bq_n;
   logic [IW-1:0] bq_id;
   assign m_aw_ready = aw_rdy;
   assign m_w_ready  = wr_tog ? wr_ph : 1'b1;
   assign m_b_valid  = b_en && (bq_n != 0);
   assign m_b_id     = bq_id;
   assign m_b_resp   = 2'b00;
   assign m_b_user   = 1'b0;

   nasti_wr_sched #(
      .N_PORT(N), .ID_WIDTH(IW), .ADDR_WIDTH(8),
      .DATA_WIDTH(8), .USER_WIDTH(1), .B_DEPTH(BD)
   ) dut (
      .clk(clk), .rst(rst),
      .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
      .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
      .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
      .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
      .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot),
      .s_aw_qos(s_aw_qos), .s_aw_region(s_aw_region),
      .s_aw_user(s_aw_user),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
      .s_w_data(s_w_data), .s_w_strb(s_w_strb),
      .s_w_last(s_w_last), .s_w_user(s_w_user),
      .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
      .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_user(s_b_user),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
      .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
      .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock),
      .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot),
      .m_aw_qos(m_aw_qos), .m_aw_region(m_aw_region),
      .m_aw_user(m_aw_user),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_w_last(m_w_last), .m_w_user(m_w_user),
`ifdef NASTI_WR_SCHED_LEN_CHK_EN
      .err(err),
`endif
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
      .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_user(m_b_user)
   );

   int ntest = 0;
   int nfail = 0;
   int done_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Model: expected grant order, burst owner, outstanding-B owner queue
   int            exp_gnt [$];
   int            gnt_log [$];
   int            own_q [$];
   logic [8:0]    wlog [$];
   logic [IW-1:0] aw_id_q [$];
   logic [IW-1:0] bq [$];
   int            owner;
   bit            open;
   int            awcnt;
   int            bcnt [N];

   initial begin
      int e, h, cport;
      bit awhs, whs, bhs, live;
      logic [8:0] lw;
      logic [IW-1:0] cid;
      owner = 0; open = 0; awcnt = 0; wr_ph = 1'b0;
      bq_n = 0; bq_id = '0;
      for (int p = 0; p < N; p++) bcnt[p] = 0;
      forever begin
         @(negedge clk);
         live = !rst;
         awhs = 0; whs = 0; bhs = 0; h = 0; cport = 0;
         if (live) begin
            e = (exp_gnt.size() != 0) ? exp_gnt[0] : -1;
            if (own_q.size() == BD) chk("aw_when_full", m_aw_valid, 0);
            if (m_aw_valid) begin
               if (e < 0) chk("aw_unexpected", m_aw_valid, 0);
               else begin
                  chk("aw_addr", m_aw_addr, s_aw_addr[e]);
                  chk("aw_len", m_aw_len, s_aw_len[e]);
                  chk("aw_id", m_aw_id, s_aw_id[e]);
                  chk("aw_size", m_aw_size, s_aw_size[e]);
                  chk("aw_region", m_aw_region, s_aw_region[e]);
                  chk("aw_ready_route", s_aw_ready, 32'(m_aw_ready) << e);
               end
            end else chk("aw_ready_idle", s_aw_ready, 0);
            if (open) begin
               chk("w_valid", m_w_valid, s_w_valid[owner]);
               if (m_w_valid) begin
                  chk("w_data", m_w_data, s_w_data[owner]);
`ifndef NASTI_WR_SCHED_LEN_CHK_EN
                  chk("w_last", m_w_last, s_w_last[owner]);
`endif
               end
               chk("w_ready_route", s_w_ready, 32'(m_w_ready) << owner);
            end else chk("w_closed", {m_w_valid, s_w_ready}, 0);
            if (own_q.size() == 0) chk("b_empty", {m_b_ready, s_b_valid}, 0);
            else begin
               h = own_q[0];
               chk("b_valid_route", s_b_valid, 32'(m_b_valid) << h);
               chk("b_ready_route", m_b_ready, s_b_ready[h]);
               if (m_b_valid) chk("b_resp", s_b_resp[h], m_b_resp);
            end
            awhs = m_aw_valid && m_aw_ready;
            whs  = m_w_valid && m_w_ready;
            bhs  = m_b_valid && m_b_ready;
            cport = (e >= 0) ? e : int'(m_aw_addr[7:6]);
            lw = {m_w_last, m_w_data};
            cid = m_aw_id;
            if (awhs) gnt_log.push_back(int'(m_aw_addr[7:6]));
         end
         @(posedge clk);
         #1;
         if (rst) begin
            own_q.delete(); wlog.delete(); aw_id_q.delete();
            bq.delete(); gnt_log.delete();
            open = 0; owner = 0; awcnt = 0;
            for (int p = 0; p < N; p++) bcnt[p] = 0;
         end else if (live) begin
            if (awhs) begin
               owner = cport; open = 1; awcnt++;
               own_q.push_back(cport);
               aw_id_q.push_back(cid);
               if (exp_gnt.size() != 0) void'(exp_gnt.pop_front());
            end
            if (whs) begin
               wlog.push_back(lw);
               if (lw[8]) begin
                  open = 0;
                  if (aw_id_q.size() != 0) bq.push_back(aw_id_q.pop_front());
               end
            end
            if (bhs) begin
               bcnt[h]++;
               if (own_q.size() != 0) void'(own_q.pop_front());
               if (bq.size() != 0) void'(bq.pop_front());
            end
         end
         bq_n = bq.size();
         bq_id = (bq_n != 0) ? bq[0] : '0;
         wr_ph = ~wr_ph;
      end
   end

   task automatic hs(input int p, input bit is_w);
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if (is_w ? s_w_ready[p] : s_aw_ready[p]) break;
         t++;
         if (t > 400) begin
            ntest++; nfail++;
            $display("FAIL hs_timeout port=%0d w=%0d actual=stalled required=handshake", p, is_w);
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic master(input int p, input int len, input int nb);
      for (int b = 0; b < nb; b++) begin
         awaddr[p] = 8'(p * 64 + b * 4);
         awlen[p] = 8'(len);
         awid[p] = IW'(p);
         awv[p] = 1'b1;
         hs(p, 0);
         awv[p] = 1'b0;
         for (int i = 0; i <= len; i++) begin
            wv[p] = 1'b1;
            wd[p] = 8'(p * 32 + i);
            wl[p] = (i == len);
            hs(p, 1);
         end
         wv[p] = 1'b0;
         wl[p] = 1'b0;
      end
      done_cnt++;
   endtask

   task automatic wait_done(input int n);
      int t;
      t = 0;
      while (done_cnt < n && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("masters_done", done_cnt, n);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int p = 0; p < N; p++) begin
         awv[p] = 0; wv[p] = 0; wl[p] = 0; bra[p] = 1;
         awaddr[p] = '0; awlen[p] = '0; awid[p] = '0; wd[p] = '0;
      end
      aw_rdy = 1; wr_tog = 0; b_en = 1; done_cnt = 0;
      exp_gnt.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      for (int p = 0; p < N; p++) begin
         awv[p] = 0; wv[p] = 0; wl[p] = 0; bra[p] = 1;
         awaddr[p] = '0; awlen[p] = '0; awid[p] = '0; wd[p] = '0;
      end
      aw_rdy = 1; wr_tog = 0; b_en = 1;
      repeat (2) @(negedge clk);
      chk("rst_m_valid", {m_aw_valid, m_w_valid, m_b_ready}, 0);
      chk("rst_s_ready", {s_aw_ready, s_w_ready, s_b_valid}, 0);
`ifdef NASTI_WR_SCHED_LEN_CHK_EN
      chk("rst_err", err, 0);
`endif

      // Single master, len=3
      do_reset();
      exp_gnt = '{0};
      fork master(0, 3, 1); join_none
      @(negedge clk);
      chk("t1_aw_cycle_t", m_aw_valid, 0);
      @(negedge clk);
      chk("t1_aw_cycle_t1", m_aw_valid, 1);
      wait_done(1);
      repeat (6) @(negedge clk);
      chk("t1_awcnt", awcnt, 1);
      chk("t1_wbeats", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++)
         chk("t1_wbeat", wlog[i], {(i == 3), 8'(i)});
      chk("t1_b_port0", bcnt[0], 1);
      chk("t1_b_others", bcnt[1] + bcnt[2] + bcnt[3], 0);

      // Fairness across ports 0,1,2
      do_reset();
      exp_gnt = '{0, 1, 2, 0, 1, 2};
      fork
         master(0, 0, 2);
         master(1, 0, 2);
         master(2, 0, 2);
      join_none
      wait_done(3);
      repeat (6) @(negedge clk);
      chk("t2_awcnt", awcnt, 6);
      chk("t2_gnt_n", gnt_log.size(), 6);
      for (int i = 0; i < 6 && i < gnt_log.size(); i++)
         chk("t2_gnt_order", gnt_log[i], i % 3);

      // FIFO full blocks the 5th burst
      do_reset();
      b_en = 0;
      exp_gnt = '{0, 1, 2, 3, 0};
      fork
         master(0, 0, 2);
         master(1, 0, 1);
         master(2, 0, 1);
         master(3, 0, 1);
      join_none
      repeat (30) @(negedge clk);
      chk("t3_awcnt_full", awcnt, 4);
      chk("t3_blocked", m_aw_valid, 0);
      chk("t3_outstanding", own_q.size(), 4);
      @(posedge clk); #1; b_en = 1;
      @(posedge clk); #1; b_en = 0;
      seen = 0;
      for (int k = 0; k < 2 && seen == 0; k++) begin
         @(negedge clk);
         if (m_aw_valid) seen = 1;
      end
      chk("t3_reissue", seen, 1);
      chk("t3_one_pop", bcnt[0], 1);
      @(posedge clk); #1; b_en = 1;
      wait_done(4);
      repeat (10) @(negedge clk);
      chk("t3_awcnt_all", awcnt, 5);
      chk("t3_b_port0", bcnt[0], 2);

      // B routed in AW order: port 2 then port 0
      do_reset();
      b_en = 0; bra[2] = 0;
      exp_gnt = '{2, 0};
      fork master(2, 0, 1); join_none
      repeat (2) @(posedge clk);
      #1;
      fork master(0, 0, 1); join_none
      wait_done(2);
      repeat (3) @(posedge clk);
      #1; b_en = 1;
      repeat (3) begin
         @(negedge clk);
         chk("t4_b_hold_p2", s_b_valid, 4'b0100);
      end
      chk("t4_p0_wait", bcnt[0] + bcnt[2], 0);
      @(posedge clk); #1; bra[2] = 1;
      repeat (5) @(negedge clk);
      chk("t4_b_p2", bcnt[2], 1);
      chk("t4_b_p0", bcnt[0], 1);

      // W backpressure, len=7 then a second port
      do_reset();
      wr_tog = 1;
      exp_gnt = '{1, 3};
      fork
         master(1, 7, 1);
         master(3, 1, 1);
      join_none
      wait_done(2);
      repeat (6) @(negedge clk);
      chk("t5_wbeats", wlog.size(), 10);
      for (int i = 0; i < 8 && i < wlog.size(); i++)
         chk("t5_wbeat", wlog[i], {(i == 7), 8'(32 + i)});
      if (wlog.size() == 10) begin
         chk("t5_p3_b0", wlog[8], 9'h060);
         chk("t5_p3_b1", wlog[9], 9'h161);
      end

`ifdef NASTI_WR_SCHED_LEN_CHK_EN
      // Early upstream w_last on a len=1 burst
      do_reset();
      exp_gnt = '{0};
      awaddr[0] = 8'h00; awlen[0] = 8'd1; awid[0] = '0; awv[0] = 1;
      hs(0, 0);
      awv[0] = 0;
      wv[0] = 1; wd[0] = 8'h00; wl[0] = 1;
      hs(0, 1);
      @(negedge clk);
      chk("t6_err_set", err, 1);
      wd[0] = 8'h01; wl[0] = 0;
      chk("t6_forced_last", m_w_last, 1);
      hs(0, 1);
      wv[0] = 0;
      @(negedge clk);
      chk("t6_idle", {m_w_valid, s_w_ready}, 0);
      chk("t6_wlog", wlog.size(), 2);
      chk("t6_err_sticky", err, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
